// File: rtl/beam_scan_ctrl_pkg.sv
// Shared types and constants for the beam scan sequencer and its power datapath.
// Words are packed {Q_x4..Q_x1, I_x4..I_x1}; the offsets below are word indices.
package beam_scan_ctrl_pkg;

  localparam int WORD_LENGTH_DEF = 16;
  localparam int N_CH            = 4;
  localparam int I_OFS           = 0;
  localparam int Q_OFS           = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_e;

  function automatic int pow_width(input int w);
    return 4 * w + 7;
  endfunction

endpackage

// File: rtl/abs_sq_cmul.sv
// Combinational |sum_c x_c * s_c|^2 over four complex channels (plain product, no conjugate).
// Intermediate sums are sized so the full-scale -32768 corner cannot overflow.
module abs_sq_cmul
  import beam_scan_ctrl_pkg::*;
#(
  parameter int WORD_LENGTH = WORD_LENGTH_DEF,
  parameter int POW_W       = pow_width(WORD_LENGTH)
) (
  input  logic [8*WORD_LENGTH-1:0] x,
  input  logic [8*WORD_LENGTH-1:0] s,
  output logic [POW_W-1:0]         pow
);

  localparam int AW = 2 * WORD_LENGTH + 3;

  function automatic logic signed [AW-1:0] word_at(input logic [8*WORD_LENGTH-1:0] v,
                                                   input int idx);
    return AW'($signed(v[idx*WORD_LENGTH +: WORD_LENGTH]));
  endfunction

  logic signed [AW-1:0]    acc_re;
  logic signed [AW-1:0]    acc_im;
  logic signed [POW_W-1:0] re_w;
  logic signed [POW_W-1:0] im_w;

  always_comb begin
    acc_re = '0;
    acc_im = '0;
    for (int c = 0; c < N_CH; c++) begin
      acc_re = acc_re + word_at(x, I_OFS + c) * word_at(s, I_OFS + c)
                      - word_at(x, Q_OFS + c) * word_at(s, Q_OFS + c);
      acc_im = acc_im + word_at(x, I_OFS + c) * word_at(s, Q_OFS + c)
                      + word_at(x, Q_OFS + c) * word_at(s, I_OFS + c);
    end
    re_w = POW_W'(acc_re);
    im_w = POW_W'(acc_im);
    pow  = re_w * re_w + im_w * im_w;
  end

endmodule

// File: rtl/beam_scan_ctrl.sv
// Latches one 4-channel snapshot, sweeps N_ANGLES steering vectors from a 1-cycle
// synchronous ROM, streams per-angle power and reports the peak angle.
module beam_scan_ctrl
  import beam_scan_ctrl_pkg::*;
#(
  parameter int WORD_LENGTH = WORD_LENGTH_DEF,
  parameter int N_ANGLES    = 181,
  parameter int ANGLE_W     = (N_ANGLES > 1) ? $clog2(N_ANGLES) : 1,
  parameter int POW_W       = pow_width(WORD_LENGTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     x_valid,
  output logic                     x_ready,
  input  logic [8*WORD_LENGTH-1:0] x_data,
  output logic                     rom_en,
  output logic [ANGLE_W-1:0]       rom_addr,
  input  logic [8*WORD_LENGTH-1:0] rom_data,
  output logic                     pow_valid,
  output logic [ANGLE_W-1:0]       pow_idx,
  output logic [POW_W-1:0]         pow,
  output logic                     out_valid,
  output logic [ANGLE_W-1:0]       best_idx,
  output logic [POW_W-1:0]         best_pow,
  output scan_state_e              dbg_state
);

  localparam logic [ANGLE_W-1:0] LAST_IDX = ANGLE_W'(N_ANGLES - 1);

  scan_state_e              state_q, state_d;
  logic [8*WORD_LENGTH-1:0] x_q, x_d;
  logic                     x_ready_q, x_ready_d;
  logic                     rom_en_q, rom_en_d;
  logic [ANGLE_W-1:0]       rom_addr_q, rom_addr_d;
  logic                     rd_valid_q, rd_valid_d;
  logic [ANGLE_W-1:0]       rd_idx_q, rd_idx_d;
  logic                     pow_valid_q, pow_valid_d;
  logic [ANGLE_W-1:0]       pow_idx_q, pow_idx_d;
  logic [POW_W-1:0]         pow_q, pow_d;
  logic                     out_valid_q, out_valid_d;
  logic [ANGLE_W-1:0]       best_idx_q, best_idx_d;
  logic [POW_W-1:0]         best_pow_q, best_pow_d;
  logic [POW_W-1:0]         result;

  abs_sq_cmul #(.WORD_LENGTH(WORD_LENGTH)) u_cmul (
    .x   (x_q),
    .s   (rom_data),
    .pow (result)
  );

  // Snapshot handshake: a transfer happens on a rising edge where x_valid and x_ready
  // are both high; x_ready is high only in IDLE and x_valid is ignored elsewhere.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    rom_en_d    = rom_en_q;
    rom_addr_d  = rom_addr_q;
    rd_valid_d  = rom_en_q;
    rd_idx_d    = rom_addr_q;
    pow_valid_d = 1'b0;
    pow_idx_d   = pow_idx_q;
    pow_d       = pow_q;
    out_valid_d = 1'b0;
    best_idx_d  = best_idx_q;
    best_pow_d  = best_pow_q;

    // Angle 0 always seeds the peak; later angles must be strictly larger.
    if (rd_valid_q) begin
      pow_valid_d = 1'b1;
      pow_d       = result;
      pow_idx_d   = rd_idx_q;
      if (rd_idx_q == '0 || result > best_pow_q) begin
        best_pow_d = result;
        best_idx_d = rd_idx_q;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (x_valid && x_ready_q) begin
          x_d        = x_data;
          rom_en_d   = 1'b1;
          rom_addr_d = '0;
          best_idx_d = '0;
          best_pow_d = '0;
          state_d    = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (rom_addr_q == LAST_IDX) begin
          rom_en_d = 1'b0;
          state_d  = ST_DRAIN;
        end else begin
          rom_addr_d = rom_addr_q + ANGLE_W'(1);
        end
      end
      // Stay until the last ROM word has been registered as a power result.
      ST_DRAIN: begin
        if (!rd_valid_q) begin
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    x_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      x_ready_q   <= 1'b1;
      rom_en_q    <= 1'b0;
      rom_addr_q  <= '0;
      rd_valid_q  <= 1'b0;
      rd_idx_q    <= '0;
      pow_valid_q <= 1'b0;
      pow_idx_q   <= '0;
      pow_q       <= '0;
      out_valid_q <= 1'b0;
      best_idx_q  <= '0;
      best_pow_q  <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      x_ready_q   <= x_ready_d;
      rom_en_q    <= rom_en_d;
      rom_addr_q  <= rom_addr_d;
      rd_valid_q  <= rd_valid_d;
      rd_idx_q    <= rd_idx_d;
      pow_valid_q <= pow_valid_d;
      pow_idx_q   <= pow_idx_d;
      pow_q       <= pow_d;
      out_valid_q <= out_valid_d;
      best_idx_q  <= best_idx_d;
      best_pow_q  <= best_pow_d;
    end
  end

  // x_ready is forced low while reset is held so nothing is offered during reset.
  assign x_ready   = x_ready_q & ~rst;
  assign rom_en    = rom_en_q;
  assign rom_addr  = rom_addr_q;
  assign pow_valid = pow_valid_q;
  assign pow_idx   = pow_idx_q;
  assign pow       = pow_q;
  assign out_valid = out_valid_q;
  assign best_idx  = best_idx_q;
  assign best_pow  = best_pow_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_beam_scan_ctrl.sv
// Self-checking bench for beam_scan_ctrl with N_ANGLES=4: directed plan cases plus
// randomized snapshots against a complex-arithmetic reference model.
module tb_beam_scan_ctrl;
  import beam_scan_ctrl_pkg::*;

  localparam int W       = 16;
  localparam int N       = 4;
  localparam int ANGLE_W = 2;
  localparam int POW_W   = 4 * W + 7;

  logic               clk;
  logic               rst;
  logic               x_valid;
  logic               x_ready;
  logic [8*W-1:0]     x_data;
  logic               rom_en;
  logic [ANGLE_W-1:0] rom_addr;
  logic [8*W-1:0]     rom_data;
  logic               pow_valid;
  logic [ANGLE_W-1:0] pow_idx;
  logic [POW_W-1:0]   pow;
  logic               out_valid;
  logic [ANGLE_W-1:0] best_idx;
  logic [POW_W-1:0]   best_pow;
  scan_state_e        dbg_state;

  logic [8*W-1:0]     rom_mem [N];
  logic [POW_W-1:0]   exp_q[$];
  int                 checks;
  int                 failures;

  beam_scan_ctrl #(.WORD_LENGTH(W), .N_ANGLES(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .x_valid   (x_valid),
    .x_ready   (x_ready),
    .x_data    (x_data),
    .rom_en    (rom_en),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .pow_valid (pow_valid),
    .pow_idx   (pow_idx),
    .pow       (pow),
    .out_valid (out_valid),
    .best_idx  (best_idx),
    .best_pow  (best_pow),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rom_en) rom_data <= rom_mem[rom_addr];
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [127:0] model_pow(input logic [8*W-1:0] xd, input logic [8*W-1:0] sd);
    longint re, im;
    logic signed [127:0] r2, i2;
    re = 0;
    im = 0;
    for (int c = 0; c < 4; c++) begin
      longint xi, xq, si, sq;
      xi = longint'($signed(xd[c*W +: W]));
      xq = longint'($signed(xd[(c+4)*W +: W]));
      si = longint'($signed(sd[c*W +: W]));
      sq = longint'($signed(sd[(c+4)*W +: W]));
      re += xi * si - xq * sq;
      im += xi * sq + xq * si;
    end
    r2 = re;
    i2 = im;
    return r2 * r2 + i2 * i2;
  endfunction

  function automatic logic [8*W-1:0] pack_uniform(input int iv, input int qv);
    logic [W-1:0] a, b;
    a = W'(iv);
    b = W'(qv);
    return {{4{b}}, {4{a}}};
  endfunction

  function automatic logic [8*W-1:0] rand_vec();
    logic [8*W-1:0] v;
    for (int c = 0; c < 8; c++) begin
      v[c*W +: W] = ($urandom_range(0, 5) == 0) ? 16'h8000 : W'($urandom);
    end
    return v;
  endfunction

  // ---------------- driver ----------------
  // Offers a snapshot, then checks every cycle after the acceptance edge E0 against
  // the timing formulas: rom_addr=k after E0+k, pow_valid(k) after E0+k+2,
  // out_valid after E0+N+2, x_ready back after E0+N+3.
  task automatic run_scan(input string tag, input logic [8*W-1:0] xd, input bit hold,
                          input bit ready_now);
    int          waitc;
    logic [127:0] p, bp;
    int          bi;
    x_data  = xd;
    x_valid = 1'b1;
    waitc   = 0;
    while (x_ready !== 1'b1 && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    if (ready_now) check({tag, ".ready_now"}, 128'(waitc), 128'd0);
    if (waitc >= 50) begin
      check({tag, ".accept_timeout"}, 128'(waitc), 128'd0);
      x_valid = 1'b0;
      return;
    end
    exp_q.delete();
    bp = '0;
    bi = 0;
    for (int k = 0; k < N; k++) begin
      p = model_pow(xd, rom_mem[k]);
      exp_q.push_back(p[POW_W-1:0]);
      if (k == 0 || p > bp) begin
        bp = p;
        bi = k;
      end
    end
    @(posedge clk);
    #1;
    x_data  = {$urandom, $urandom, $urandom, $urandom};
    x_valid = hold;
    for (int m = 0; m <= N + 3; m++) begin
      @(negedge clk);
      check({tag, ".rom_en"}, 128'(rom_en), 128'(m < N));
      if (m < N) check({tag, ".rom_addr"}, 128'(rom_addr), 128'(m));
      check({tag, ".pow_valid"}, 128'(pow_valid), 128'(m >= 2 && m <= N + 1));
      if (pow_valid === 1'b1 && exp_q.size() > 0) begin
        check({tag, ".pow"}, 128'(pow), 128'(exp_q.pop_front()));
        check({tag, ".pow_idx"}, 128'(pow_idx), 128'(m - 2));
      end
      check({tag, ".out_valid"}, 128'(out_valid), 128'(m == N + 2));
      if (m >= N + 2) begin
        check({tag, ".best_idx"}, 128'(best_idx), 128'(bi));
        check({tag, ".best_pow"}, 128'(best_pow), bp);
      end
      check({tag, ".x_ready"}, 128'(x_ready), 128'(m == N + 3));
    end
    check({tag, ".exp_q_empty"}, 128'(exp_q.size()), 128'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    x_valid  = 1'b0;
    x_data   = '0;
    rom_data = '0;
    for (int k = 0; k < N; k++) rom_mem[k] = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.x_ready", 128'(x_ready), 128'd0);
    check("rst.rom_en", 128'(rom_en), 128'd0);
    check("rst.rom_addr", 128'(rom_addr), 128'd0);
    check("rst.pow_valid", 128'(pow_valid), 128'd0);
    check("rst.pow", 128'(pow), 128'd0);
    check("rst.out_valid", 128'(out_valid), 128'd0);
    check("rst.best_pow", 128'(best_pow), 128'd0);
    check("rst.state", 128'(dbg_state), 128'(ST_IDLE));
    rst = 1'b0;
    @(negedge clk);
    check("rst.x_ready_after", 128'(x_ready), 128'd1);

    // Peak at last angle
    for (int k = 0; k < N; k++) rom_mem[k] = pack_uniform(k, 0);
    run_scan("t1", pack_uniform(1, 0), 1'b0, 1'b0);
    check("t1.best_idx_abs", 128'(best_idx), 128'd3);
    check("t1.best_pow_abs", 128'(best_pow), 128'd144);

    // Tie handling
    for (int k = 0; k < N; k++) rom_mem[k] = pack_uniform(1, 0);
    run_scan("t2", pack_uniform(1, 0), 1'b0, 1'b0);
    check("t2.best_idx_abs", 128'(best_idx), 128'd0);
    check("t2.best_pow_abs", 128'(best_pow), 128'd16);

    // Full-scale negative corner
    for (int k = 0; k < N; k++) rom_mem[k] = '0;
    rom_mem[2] = pack_uniform(-32768, -32768);
    run_scan("t3", pack_uniform(-32768, -32768), 1'b0, 1'b0);
    check("t3.best_idx_abs", 128'(best_idx), 128'd2);
    check("t3.best_pow_abs", 128'(best_pow), 128'd1 << 66);

    // Mixed I/Q
    for (int k = 0; k < N; k++) rom_mem[k] = '0;
    rom_mem[1] = pack_uniform(-2, 2);
    run_scan("t6", pack_uniform(-1, 1), 1'b0, 1'b0);
    check("t6.best_idx_abs", 128'(best_idx), 128'd1);
    check("t6.best_pow_abs", 128'(best_pow), 128'd256);

    // Back-to-back with x_valid held and x_data scrambled during the scan
    for (int k = 0; k < N; k++) rom_mem[k] = rand_vec();
    run_scan("t4a", rand_vec(), 1'b1, 1'b0);
    run_scan("t4b", rand_vec(), 1'b1, 1'b1);
    run_scan("t4c", rand_vec(), 1'b0, 1'b1);

    // Randomized snapshots and steering tables
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < N; k++) rom_mem[k] = rand_vec();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_scan("rnd", rand_vec(), 1'(r % 2), 1'b0);
    end

    // Reset mid-scan at the cycle rom_addr=2 is driven
    for (int k = 0; k < N; k++) rom_mem[k] = rand_vec();
    x_data  = rand_vec();
    x_valid = 1'b1;
    @(posedge clk);
    #1;
    x_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("t5.rom_addr", 128'(rom_addr), 128'd2);
    rst = 1'b1;
    @(negedge clk);
    check("t5.x_ready_in_rst", 128'(x_ready), 128'd0);
    check("t5.rom_en", 128'(rom_en), 128'd0);
    check("t5.rom_addr0", 128'(rom_addr), 128'd0);
    check("t5.pow", 128'(pow), 128'd0);
    check("t5.pow_idx", 128'(pow_idx), 128'd0);
    check("t5.best_idx", 128'(best_idx), 128'd0);
    check("t5.best_pow", 128'(best_pow), 128'd0);
    rst = 1'b0;
    for (int m = 0; m < 8; m++) begin
      @(negedge clk);
      if (m == 0) check("t5.x_ready_after", 128'(x_ready), 128'd1);
      check("t5.no_out_valid", 128'(out_valid), 128'd0);
      check("t5.no_pow_valid", 128'(pow_valid), 128'd0);
    end

    // Block must still work after the abort
    for (int k = 0; k < N; k++) rom_mem[k] = pack_uniform(k, 0);
    run_scan("t5post", pack_uniform(1, 0), 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
